// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver with a first-word-fall-through byte FIFO.
// rx is synchronised, deframed at a fixed bit period and buffered; the FIFO head
// is presented on a registered valid/ready interface.
module uart_rx_fifo #(
    parameter int unsigned UART_PERIOD = 868,
    parameter int unsigned FIFO_AW     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx,
    output logic [7:0]         rd_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [FIFO_AW:0]   count,
    output logic               overrun,
    output logic               frame_err,
    input  logic               clr_err
);

    localparam int unsigned TW = $clog2(UART_PERIOD);
    localparam int unsigned PW = FIFO_AW + 1;
    localparam logic [TW-1:0] HALF_LOAD = TW'(UART_PERIOD / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(UART_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    logic          rx_meta;
    logic          rxs;
    logic          rxs_d;
    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          push_c;
    logic          ferr_set_c;
    logic          expired_c;

    // Two-flop synchroniser plus one history flop for start-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    // Deframer state, bit timer, bit index and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            idx   <= idx_n;
            shreg <= shreg_n;
        end
    end

    assign expired_c = (timer == '0);

    // Deframer next state: sample at each timer expiry, never stalls on the FIFO
    always_comb begin
        state_n    = state;
        timer_n    = expired_c ? timer : timer - TW'(1);
        idx_n      = idx;
        shreg_n    = shreg;
        push_c     = 1'b0;
        ferr_set_c = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs && rxs_d) begin
                    timer_n = HALF_LOAD;
                    state_n = START;
                end
            end
            START: begin
                if (expired_c) begin
                    if (!rxs) begin
                        timer_n = FULL_LOAD;
                        idx_n   = 3'd0;
                        state_n = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (expired_c) begin
                    shreg_n = {rxs, shreg[7:1]};
                    timer_n = FULL_LOAD;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (expired_c) begin
                    if (rxs) begin
                        push_c = 1'b1;
                    end else begin
                        ferr_set_c = 1'b1;
                    end
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [0:(1 << FIFO_AW) - 1];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] wr_ptr_n, rd_ptr_n;
    logic [PW-1:0] count_n;
    logic [7:0]    head_c;
    logic          full_c;
    logic          pop_c;
    logic          wr_en_c;
    logic          ovr_set_c;

    // Pointer arithmetic; a full FIFO still accepts a byte when the head leaves the same cycle
    always_comb begin
        full_c    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
        pop_c     = rd_valid & rd_ready;
        wr_en_c   = push_c & (~full_c | pop_c);
        ovr_set_c = push_c & full_c & ~pop_c;
        wr_ptr_n  = wr_ptr + PW'(wr_en_c);
        rd_ptr_n  = rd_ptr + PW'(pop_c);
        count_n   = wr_ptr_n - rd_ptr_n;
        // New head is the incoming byte when it lands exactly at the next read slot
        if (wr_en_c && (rd_ptr_n == wr_ptr)) begin
            head_c = shreg;
        end else begin
            head_c = mem[rd_ptr_n[FIFO_AW-1:0]];
        end
    end

    // Storage array, no reset needed since pointers qualify every entry
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
        end
    end

    // Pointers, registered head, occupancy and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            count     <= count_n;
            rd_valid  <= (count_n != '0);
            rd_data   <= head_c;
            overrun   <= ovr_set_c | (overrun & ~clr_err);
            frame_err <= ferr_set_c | (frame_err & ~clr_err);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based model of received frames and the FIFO.
module tb_uart_rx_fifo;

    localparam int unsigned P     = 5;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    // Start edge on the pin -> 2 sync + 1 edge cycle + half bit + 9 full bits to stop centre
    localparam int unsigned LAT   = 3 + P / 2 + 9 * P;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW:0]   count;
    logic          overrun;
    logic          frame_err;
    logic          clr_err;

    uart_rx_fifo #(
        .UART_PERIOD (P),
        .FIFO_AW     (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .count     (count),
        .overrun   (overrun),
        .frame_err (frame_err),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit done   = 1'b0;
    bit rnd_done;

    // Frames scheduled by the transmitter: completion cycle, byte, stop-bit level
    int         ev_t  [512];
    logic [7:0] ev_b  [512];
    bit         ev_ok [512];
    int         ev_wr = 0;
    int         ev_rd = 0;

    // Model state
    int   mq [$];
    bit   m_ovr = 1'b0;
    bit   m_fe  = 1'b0;
    bit   m_pop, m_full, m_psh, m_fset, m_oset;
    int   m_pb;

    logic [7:0] b;
    bit         ok;
    int         g;
    int         thr;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Behavioural model: frames complete at a fixed latency, FIFO is a queue
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            mq.delete();
            m_ovr = 1'b0;
            m_fe  = 1'b0;
            ev_rd = ev_wr;
        end else begin
            m_pop  = (mq.size() != 0) && (rd_ready === 1'b1);
            m_full = (mq.size() == DEPTH);
            m_psh  = 1'b0;
            m_fset = 1'b0;
            m_oset = 1'b0;
            while (ev_rd != ev_wr && ev_t[ev_rd] <= cyc) begin
                if (ev_t[ev_rd] == cyc) begin
                    if (ev_ok[ev_rd]) begin
                        m_psh = 1'b1;
                        m_pb  = int'(ev_b[ev_rd]);
                    end else begin
                        m_fset = 1'b1;
                    end
                end
                ev_rd++;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_psh) begin
                if (m_full && !m_pop) m_oset = 1'b1;
                else mq.push_back(m_pb);
            end
            m_ovr = m_oset | (m_ovr & !clr_err);
            m_fe  = m_fset | (m_fe & !clr_err);
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit stop_ok);
        ev_t[ev_wr]  = cyc + LAT;
        ev_b[ev_wr]  = d;
        ev_ok[ev_wr] = stop_ok;
        ev_wr++;
        rx = 1'b0;
        repeat (P) begin @(posedge clk); #1; end
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (P) begin @(posedge clk); #1; end
        end
        rx = stop_ok;
        repeat (P) begin @(posedge clk); #1; end
        rx = 1'b1;
    endtask

    task automatic pop_expect(input string name, input int exp);
        chk({name, "_valid"}, int'(rd_valid), 1);
        chk({name, "_data"}, int'(rd_data), exp);
        rd_ready = 1'b1;
        @(posedge clk); #1;
        rd_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        rx       = 1'b1;
        rd_ready = 1'b0;
        clr_err  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_count", int'(count), 0);
        chk("reset_valid", int'(rd_valid), 0);
        chk("reset_data", int'(rd_data), 0);
        rst_n = 1'b1;
        idle(4);

        fork
            begin
                // Single byte
                send_byte(8'h4A, 1'b1);
                chk("t1_valid", int'(rd_valid), 1);
                chk("t1_count", int'(count), 1);
                pop_expect("t1_pop", 'h4A);
                chk("t1_count_after", int'(count), 0);
                chk("t1_valid_after", int'(rd_valid), 0);
                idle(P);

                // Back-to-back frames
                send_byte(8'h66, 1'b1);
                send_byte(8'h30, 1'b1);
                chk("t2_count", int'(count), 2);
                pop_expect("t2_pop0", 'h66);
                pop_expect("t2_pop1", 'h30);
                idle(P);

                // Overflow
                for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
                chk("t3_count", int'(count), 16);
                chk("t3_overrun", int'(overrun), 1);
                for (int i = 0; i < 16; i++) pop_expect("t3_pop", i);
                chk("t3_empty", int'(count), 0);
                pulse_clr();
                chk("t3_clr", int'(overrun), 0);

                // Pop coinciding with a push into a full FIFO
                for (int i = 0; i < 16; i++) send_byte(8'(32 + i), 1'b1);
                fork
                    send_byte(8'h77, 1'b1);
                    begin
                        repeat (LAT - 1) begin @(posedge clk); #1; end
                        rd_ready = 1'b1;
                        @(posedge clk); #1;
                        rd_ready = 1'b0;
                    end
                join
                chk("t4_count", int'(count), 16);
                chk("t4_overrun", int'(overrun), 0);
                for (int i = 0; i < 16; i++) pop_expect("t4_pop", (i < 15) ? (33 + i) : 'h77);

                // Framing error then a good byte
                send_byte(8'h55, 1'b0);
                idle(2 * P);
                chk("t5_ferr", int'(frame_err), 1);
                chk("t5_count", int'(count), 0);
                send_byte(8'h3C, 1'b1);
                pop_expect("t5_pop", 'h3C);
                pulse_clr();
                chk("t5_clr", int'(frame_err), 0);

                // Glitch, then reset mid-frame
                rx = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
                idle(12 * P);
                chk("t6_glitch_count", int'(count), 0);
                chk("t6_glitch_ferr", int'(frame_err), 0);
                send_byte(8'hA5, 1'b1);
                chk("t6_pre_count", int'(count), 1);
                rx = 1'b0;
                repeat (3 * P) begin @(posedge clk); #1; end
                rst_n = 1'b0;
                #1;
                chk("t6_rst_count", int'(count), 0);
                chk("t6_rst_valid", int'(rd_valid), 0);
                chk("t6_rst_data", int'(rd_data), 0);
                chk("t6_rst_ovr", int'(overrun), 0);
                chk("t6_rst_ferr", int'(frame_err), 0);
                rx = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                idle(4 * P);
                send_byte(8'h96, 1'b1);
                chk("t6_count", int'(count), 1);
                pop_expect("t6_pop", 'h96);

                // Randomized traffic: slow consumer then fast consumer
                for (int r = 0; r < 2; r++) begin
                    thr      = (r == 0) ? 12 : 70;
                    rnd_done = 1'b0;
                    fork
                        begin
                            for (int k = 0; k < 60; k++) begin
                                b  = 8'($urandom);
                                ok = ($urandom_range(0, 7) != 0);
                                g  = ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
                                send_byte(b, ok);
                                idle(g * P);
                            end
                            rnd_done = 1'b1;
                        end
                        begin
                            while (!rnd_done) begin
                                rd_ready = ($urandom_range(0, 99) < thr);
                                clr_err  = ($urandom_range(0, 49) == 0);
                                @(posedge clk); #1;
                            end
                            rd_ready = 1'b0;
                            clr_err  = 1'b0;
                        end
                    join
                end
                rd_ready = 1'b1;
                repeat (40) begin @(posedge clk); #1; end
                rd_ready = 1'b0;
                pulse_clr();
                chk("drain_count", int'(count), 0);
                chk("drain_ovr", int'(overrun), 0);
                chk("drain_ferr", int'(frame_err), 0);
                done = 1'b1;
            end
            begin
                // Per-cycle comparison against the model, away from the active edge
                while (!done) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        chk("mon_rst_count", int'(count), 0);
                        chk("mon_rst_valid", int'(rd_valid), 0);
                        chk("mon_rst_ovr", int'(overrun), 0);
                        chk("mon_rst_ferr", int'(frame_err), 0);
                    end else begin
                        chk("mon_count", int'(count), mq.size());
                        chk("mon_valid", int'(rd_valid), (mq.size() != 0) ? 1 : 0);
                        if (mq.size() != 0) chk("mon_data", int'(rd_data), mq[0]);
                        chk("mon_overrun", int'(overrun), int'(m_ovr));
                        chk("mon_frame_err", int'(frame_err), int'(m_fe));
                    end
                end
            end
        join

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
